// File: rtl/eflags_writeback_if.sv
// eflags_writeback bus: issue/writeback handshake, committed flags
// and condition-code query between the pipeline and the flags unit.
interface eflags_writeback_if;
  logic        iss_valid;
  logic        iss_ready;
  logic        wb_valid;
  logic [2:0]  wb_op;
  logic [31:0] wb_flags;
  logic        flush;
  logic [31:0] eflags;
  logic        flags_busy;
  logic [3:0]  cc;
  logic        cc_true;
  logic        cc_valid;
  logic        err;

  modport master (
    output iss_valid, wb_valid, wb_op, wb_flags, flush, cc,
    input  iss_ready, eflags, flags_busy, cc_true, cc_valid, err
  );

  modport slave (
    input  iss_valid, wb_valid, wb_op, wb_flags, flush, cc,
    output iss_ready, eflags, flags_busy, cc_true, cc_valid, err
  );
endinterface

// File: rtl/eflags_writeback.sv
// Architectural EFLAGS, in-flight flag-writer scoreboard, tttn eval.
// Define EFLAGS_CC_EVAL_EN to build the condition evaluator.
module eflags_writeback #(
  parameter int PENDING_DEPTH = 4,
  parameter int CNT_W         = 3
) (
  input logic               clk,
  input logic               reset,
  eflags_writeback_if.slave bus
);

  localparam logic [31:0] STAT_M = 32'h0000_08D5;
  localparam logic [31:0] DF_M   = 32'h0000_0400;
  localparam logic [31:0] FIX1   = 32'h0000_0002;
  localparam logic [31:0] LIVE_M = STAT_M | DF_M;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PENDING_DEPTH);

  logic [CNT_W-1:0] count;
  logic [31:0]      flags_q;
  logic             err_q;
  logic [31:0]      wmask;
  logic [31:0]      next_flags;
  logic             issue;
  logic             retire;
  logic             bad_wb;

  assign bus.iss_ready = ~bus.flush & (count < FULL);
  assign issue  = bus.iss_valid & bus.iss_ready;
  assign retire = bus.wb_valid & (count != '0);
  assign bad_wb = bus.wb_valid & (count == '0) & ~bus.flush;

  // Which architectural flags the retiring op owns.
  always_comb begin
    wmask = '0;
    unique case (bus.wb_op)
      3'd0, 3'd1, 3'd3, 3'd4, 3'd6: wmask = STAT_M;
      3'd5, 3'd7:                   wmask = DF_M;
      default:                      wmask = '0;
    endcase
  end

  assign next_flags =
    (((flags_q & ~wmask) | (bus.wb_flags & wmask)) & LIVE_M) | FIX1;

  // Pending flag-writer count; flush drops all younger writers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else if (issue && !retire) begin
      count <= count + ONE;
    end else if (retire && !issue) begin
      count <= count - ONE;
    end
  end

  // Commit owned flags of a legal writeback, even alongside flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FIX1;
    end else if (retire) begin
      flags_q <= next_flags;
    end
  end

  // Sticky error for a writeback with nothing in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (bad_wb) begin
      err_q <= 1'b1;
    end
  end

  assign bus.eflags     = flags_q;
  assign bus.flags_busy = (count != '0);
  assign bus.cc_valid   = (count == '0);
  assign bus.err        = err_q;

`ifdef EFLAGS_CC_EVAL_EN
  logic cf, pf, zf, sf, of_b, cc_hit;

  assign cf   = flags_q[0];
  assign pf   = flags_q[2];
  assign zf   = flags_q[6];
  assign sf   = flags_q[7];
  assign of_b = flags_q[11];

  // tttn decode against committed flags only, no bypass.
  always_comb begin
    cc_hit = 1'b0;
    unique case (bus.cc)
      4'h0: cc_hit = of_b;
      4'h1: cc_hit = ~of_b;
      4'h2: cc_hit = cf;
      4'h3: cc_hit = ~cf;
      4'h4: cc_hit = zf;
      4'h5: cc_hit = ~zf;
      4'h6: cc_hit = cf | zf;
      4'h7: cc_hit = ~(cf | zf);
      4'h8: cc_hit = sf;
      4'h9: cc_hit = ~sf;
      4'hA: cc_hit = pf;
      4'hB: cc_hit = ~pf;
      4'hC: cc_hit = sf ^ of_b;
      4'hD: cc_hit = ~(sf ^ of_b);
      4'hE: cc_hit = zf | (sf ^ of_b);
      4'hF: cc_hit = ~(zf | (sf ^ of_b));
      default: cc_hit = 1'b0;
    endcase
  end

  assign bus.cc_true = cc_hit;
`else
  logic unused_cc;
  assign unused_cc   = ^bus.cc;
  assign bus.cc_true = 1'b0;
`endif

endmodule

// File: tb/tb_eflags_writeback.sv
// Self-checking bench for eflags_writeback with a behavioural model.
// Directed scenarios from the test plan plus a randomized soak.
module tb_eflags_writeback;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  eflags_writeback_if bus ();

  eflags_writeback #(
    .PENDING_DEPTH(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int          m_cnt;
  logic [31:0] m_fl;
  logic        m_err;
  logic        exp_rdy;
  logic        rdy_seen;

  function automatic logic [31:0] apply_op(
    input logic [31:0] cur,
    input int          op,
    input logic [31:0] src
  );
    int stat_bits[6] = '{0, 2, 4, 6, 7, 11};
    logic [31:0] r;
    r = cur;
    if (op == 0 || op == 1 || op == 3 || op == 4 || op == 6) begin
      foreach (stat_bits[k]) r[stat_bits[k]] = src[stat_bits[k]];
    end else if (op == 5 || op == 7) begin
      r[10] = src[10];
    end
    return r;
  endfunction

  function automatic logic cc_ref(
    input logic [3:0]  c,
    input logic [31:0] f
  );
    logic base;
    logic sx;
    sx = f[7] ^ f[11];
    case (int'(c) / 2)
      0: base = f[11];
      1: base = f[0];
      2: base = f[6];
      3: base = f[0] | f[6];
      4: base = f[7];
      5: base = f[2];
      6: base = sx;
      default: base = f[6] | sx;
    endcase
`ifdef EFLAGS_CC_EVAL_EN
    return base ^ c[0];
`else
    return 1'b0 & base;
`endif
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_fl  = 32'h0000_0002;
    m_err = 1'b0;
  endtask

  // Drive one cycle of stimulus and advance the model.
  task automatic tick(
    input logic        iv,
    input logic        wv,
    input logic [2:0]  op,
    input logic [31:0] fl,
    input logic        fls
  );
    logic iss;
    logic ret;
    bus.iss_valid = iv;
    bus.wb_valid  = wv;
    bus.wb_op     = op;
    bus.wb_flags  = fl;
    bus.flush     = fls;
    #1;
    rdy_seen = bus.iss_ready;
    exp_rdy  = !fls && (m_cnt < 4);
    iss = iv && exp_rdy;
    ret = wv && (m_cnt != 0);
    if (wv && m_cnt == 0 && !fls) m_err = 1'b1;
    if (ret) m_fl = apply_op(m_fl, int'(op), fl);
    if (fls) m_cnt = 0;
    else m_cnt = m_cnt + int'(iss) - int'(ret);
    @(posedge clk);
    #1;
    bus.iss_valid = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if (bus.eflags !== 32'h0000_0002) begin
      $display("FAIL reset_eflags got=%h exp=%h", bus.eflags, 32'h2);
      failures++;
    end
    checks++;
    if ({bus.iss_ready, bus.flags_busy, bus.cc_valid, bus.err}
        !== 4'b1010) begin
      $display("FAIL reset_ctl got=%b exp=1010",
               {bus.iss_ready, bus.flags_busy, bus.cc_valid, bus.err});
      failures++;
    end
  endtask

  task automatic test_add();
    tick(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
    checks++;
    if (bus.flags_busy !== 1'b1 || bus.cc_valid !== 1'b0) begin
      $display("FAIL add_busy got=%b%b exp=10",
               bus.flags_busy, bus.cc_valid);
      failures++;
    end
    tick(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (bus.eflags !== m_fl || m_fl !== 32'h0000_08D7) begin
      $display("FAIL add_eflags got=%h exp=%h", bus.eflags, m_fl);
      failures++;
    end
    checks++;
    if (bus.flags_busy !== 1'b0 || bus.cc_valid !== 1'b1) begin
      $display("FAIL add_idle got=%b%b exp=01",
               bus.flags_busy, bus.cc_valid);
      failures++;
    end
    bus.cc = 4'h4;
    #1;
    checks++;
    if (bus.cc_true !== cc_ref(4'h4, m_fl)) begin
      $display("FAIL add_cc_e got=%b exp=%b",
               bus.cc_true, cc_ref(4'h4, m_fl));
      failures++;
    end
  endtask

  task automatic test_df();
    tick(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 3'd5, 32'h0, 1'b0);
    checks++;
    if (bus.eflags !== 32'h0000_08D7) begin
      $display("FAIL cld_eflags got=%h exp=%h", bus.eflags, 32'h8D7);
      failures++;
    end
    tick(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (bus.eflags !== 32'h0000_0CD7 || m_fl !== 32'h0000_0CD7) begin
      $display("FAIL std_eflags got=%h exp=%h", bus.eflags, 32'hCD7);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
      checks++;
      if (rdy_seen !== 1'b1) begin
        $display("FAIL b2b_ready%0d got=%b exp=1", i, rdy_seen);
        failures++;
      end
    end
    tick(1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (rdy_seen !== 1'b0 || exp_rdy !== 1'b0) begin
      $display("FAIL full_ready got=%b exp=0", rdy_seen);
      failures++;
    end
    checks++;
    if (bus.eflags !== 32'h0000_0CD7) begin
      $display("FAIL not_eflags got=%h exp=%h", bus.eflags, 32'hCD7);
      failures++;
    end
    checks++;
    if (bus.iss_ready !== (m_cnt < 4) || bus.flags_busy !== 1'b1) begin
      $display("FAIL freed_slot got=%b%b exp=%b1",
               bus.iss_ready, bus.flags_busy, m_cnt < 4);
      failures++;
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 1'b1, 3'd6, 32'h0000_0001, 1'b1);
    checks++;
    if (rdy_seen !== 1'b0) begin
      $display("FAIL flush_ready got=%b exp=0", rdy_seen);
      failures++;
    end
    checks++;
    if (bus.eflags !== 32'h0000_0403 || bus.eflags !== m_fl) begin
      $display("FAIL flush_eflags got=%h exp=%h", bus.eflags, 32'h403);
      failures++;
    end
    checks++;
    if ({bus.flags_busy, bus.cc_valid, bus.err} !== 3'b010) begin
      $display("FAIL flush_ctl got=%b exp=010",
               {bus.flags_busy, bus.cc_valid, bus.err});
      failures++;
    end
  endtask

  task automatic test_err();
    tick(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (bus.eflags !== 32'h0000_0403 || bus.err !== 1'b1) begin
      $display("FAIL err_set got=%h/%b exp=00000403/1",
               bus.eflags, bus.err);
      failures++;
    end
    tick(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0);
    tick(1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
    checks++;
    if (bus.err !== 1'b1 || bus.eflags !== m_fl) begin
      $display("FAIL err_hold got=%b/%h exp=1/%h",
               bus.err, bus.eflags, m_fl);
      failures++;
    end
    bus.iss_valid = 1'b1;
    bus.wb_valid  = 1'b1;
    bus.wb_op     = 3'd7;
    bus.wb_flags  = 32'hFFFF_FFFF;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.iss_valid = 1'b0;
    bus.wb_valid  = 1'b0;
    model_reset();
    checks++;
    if (bus.eflags !== 32'h0000_0002 || bus.err !== 1'b0 ||
        bus.flags_busy !== 1'b0) begin
      $display("FAIL err_reset got=%h/%b/%b exp=00000002/0/0",
               bus.eflags, bus.err, bus.flags_busy);
      failures++;
    end
  endtask

  task automatic test_cc();
    logic [3:0] c;
    tick(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 3'd0, 32'h0000_0080, 1'b0);
    for (int i = 12; i < 16; i++) begin
      c = 4'(i);
      bus.cc = c;
      #1;
      checks++;
      if (bus.cc_true !== cc_ref(c, m_fl)) begin
        $display("FAIL cc_%h got=%b exp=%b",
                 c, bus.cc_true, cc_ref(c, m_fl));
        failures++;
      end
    end
  endtask

  task automatic test_random();
    logic        iv, wv, fls;
    logic [2:0]  op;
    logic [31:0] fl;
    for (int n = 0; n < 400; n++) begin
      iv  = 1'($urandom_range(0, 1));
      wv  = (m_cnt != 0) ? 1'($urandom_range(0, 1))
                         : ($urandom_range(0, 40) == 0);
      fls = ($urandom_range(0, 15) == 0);
      op  = 3'($urandom_range(0, 7));
      fl  = $urandom;
      bus.cc = 4'($urandom_range(0, 15));
      tick(iv, wv, op, fl, fls);
      checks++;
      if (rdy_seen !== exp_rdy) begin
        $display("FAIL rnd_ready n=%0d got=%b exp=%b",
                 n, rdy_seen, exp_rdy);
        failures++;
      end
      checks++;
      if (bus.eflags !== m_fl || bus.err !== m_err ||
          bus.flags_busy !== (m_cnt != 0) ||
          bus.cc_valid !== (m_cnt == 0) ||
          bus.cc_true !== cc_ref(bus.cc, m_fl)) begin
        $display("FAIL rnd_state n=%0d got=%h/%b%b%b%b exp=%h/%b%b%b%b",
                 n, bus.eflags, bus.err, bus.flags_busy,
                 bus.cc_valid, bus.cc_true, m_fl, m_err,
                 m_cnt != 0, m_cnt == 0, cc_ref(bus.cc, m_fl));
        failures++;
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.iss_valid = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_op     = 3'd0;
    bus.wb_flags  = 32'h0;
    bus.flush     = 1'b0;
    bus.cc        = 4'h0;
    model_reset();
    test_reset();
    test_add();
    test_df();
    test_back_to_back();
    test_flush();
    test_err();
    test_cc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
